// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: PC register, word-addressed instruction memory
// loaded by the debug unit, and a registered {pc+1, instruction} output pair.
module instruction_fetch_unit #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] NOP_WORD  = 32'hF8000000,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFC000000
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               stall_i,
    input  logic               jump_or_branch_i,
    input  logic [NB_ADDR-1:0] target_addr_i,
    input  logic               wr_en_i,
    input  logic [NB_ADDR-1:0] wr_addr_i,
    input  logic [NB_DATA-1:0] wr_data_i,
    output logic [NB_ADDR-1:0] pc_o,
    output logic [NB_DATA-1:0] instruction_o,
    output logic               valid_o,
    output logic               halt_o,
    output logic [NB_ADDR-1:0] pc_current_o
);

    localparam int                 DEPTH    = 1 << NB_ADDR;
    localparam logic [NB_ADDR-1:0] ADDR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    state_t             r_state;
    logic [NB_ADDR-1:0] r_pc;
    logic [NB_ADDR-1:0] r_pc_o;
    logic [NB_DATA-1:0] r_instr;
    logic               r_valid;

    state_t             w_state_next;
    logic [NB_ADDR-1:0] w_pc_next;
    logic [NB_ADDR-1:0] w_pc_o_next;
    logic [NB_DATA-1:0] w_instr_next;
    logic               w_valid_next;
    logic [NB_ADDR-1:0] w_pc_inc;
    logic [NB_DATA-1:0] w_fetch_word;
    logic               w_advance;

    // Memory is never reset; the nonblocking write makes same-cycle reads see the old word.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign w_fetch_word = r_mem[r_pc];
    assign w_pc_inc     = r_pc + ADDR_ONE;
    assign w_advance    = enable_i && !stall_i;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pc_o_next  = r_pc_o;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        case (r_state)
            ST_RUN: begin
                if (w_advance) begin
                    if (jump_or_branch_i) begin
                        w_pc_next    = target_addr_i;
                        w_instr_next = NOP_WORD;
                        w_valid_next = 1'b0;
                    end else begin
                        w_instr_next = w_fetch_word;
                        w_pc_o_next  = w_pc_inc;
                        w_valid_next = 1'b1;
                        // HALT is emitted as a normal fetch but the PC stays on it.
                        if (w_fetch_word == HALT_WORD) begin
                            w_state_next = ST_HALTED;
                        end else begin
                            w_pc_next = w_pc_inc;
                        end
                    end
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_pc_o  <= '0;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_pc_o  <= w_pc_o_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
        end
    end

    assign pc_o          = r_pc_o;
    assign instruction_o = r_instr;
    assign valid_o       = r_valid;
    assign halt_o        = (r_state == ST_HALTED);
    assign pc_current_o  = r_pc;

endmodule
